// File: rtl/fifo_wr_arb.sv
// Round-robin write-port arbiter sharing one FIFO write port among NUM_REQ requesters.
// Define FIFO_WR_ARB_BURST_EN to let a granted requester hold the port for up to MAX_BURST words.
module fifo_wr_arb #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NUM_REQ-1:0]              req_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data_i,
    input  logic                            full_i,
    output logic [NUM_REQ-1:0]              ack_o,
    output logic                            w_inc_o,
    output logic [DATA_WIDTH-1:0]           wr_data_o,
    output logic [$clog2(NUM_REQ)-1:0]      gnt_id_o,
    output logic [15:0]                     wr_cnt_o
);

    localparam int unsigned ID_W   = $clog2(NUM_REQ);
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned BCNT_W = 4;
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

    generate
        if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_cfg
            $error("fifo_wr_arb: NUM_REQ must be 2..8 and MAX_BURST 1..15");
        end
    endgenerate

    function automatic logic [ID_W-1:0] inc_id(input logic [ID_W-1:0] id);
        return (id == LAST_ID) ? '0 : id + ID_W'(1);
    endfunction

    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [ID_W-1:0]  start;
    logic [ID_W-1:0]  scan;
    logic [ID_W-1:0]  win;
    logic             found;
    logic             accept;

`ifdef FIFO_WR_ARB_BURST_EN
    localparam logic [0:0] ST_ARB  = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [ID_W-1:0]   owner_q, owner_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic [BCNT_W-1:0] bcnt_inc;
    logic              owner_hold;
`endif

    // Winner select: rotating scan from the pointer; a live burst owner overrides it.
    always_comb begin
        start = ptr_q;
        found = 1'b0;
        win   = '0;
`ifdef FIFO_WR_ARB_BURST_EN
        owner_hold = (state_q == ST_LOCK) && req_i[owner_q];
        if (state_q == ST_LOCK) begin
            start = inc_id(owner_q);
        end
`endif
        scan = start;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            if (!found && req_i[scan]) begin
                found = 1'b1;
                win   = scan;
            end
            scan = inc_id(scan);
        end
`ifdef FIFO_WR_ARB_BURST_EN
        if (owner_hold) begin
            found = 1'b1;
            win   = owner_q;
        end
`endif
        accept = found && !full_i && !rst_i;
    end

    // Zero-latency write port towards the FIFO.
    always_comb begin
        ack_o     = '0;
        w_inc_o   = accept;
        wr_data_o = '0;
        if (accept) begin
            ack_o[win] = 1'b1;
            wr_data_o  = req_data_i[32'(win) * DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        ptr_d    = ptr_q;
        gnt_id_d = gnt_id_q;
        wr_cnt_d = wr_cnt_q;
        if (accept) begin
            gnt_id_d = win;
            wr_cnt_d = wr_cnt_q + CNT_W'(1);
        end
`ifdef FIFO_WR_ARB_BURST_EN
        state_d  = state_q;
        owner_d  = owner_q;
        bcnt_d   = bcnt_q;
        bcnt_inc = bcnt_q + BCNT_W'(1);
        case (state_q)
            ST_LOCK: begin
                if (!full_i) begin
                    if (owner_hold) begin
                        bcnt_d = bcnt_inc;
                        if (bcnt_inc == BCNT_W'(MAX_BURST)) begin
                            state_d = ST_ARB;
                            ptr_d   = inc_id(owner_q);
                            bcnt_d  = '0;
                        end
                    end else begin
                        // Owner went idle: release and let the same-cycle winner start its own burst.
                        state_d = ST_ARB;
                        ptr_d   = inc_id(owner_q);
                        bcnt_d  = '0;
                        if (accept) begin
                            owner_d = win;
                            bcnt_d  = BCNT_W'(1);
                            if (MAX_BURST == 1) begin
                                ptr_d = inc_id(win);
                            end else begin
                                state_d = ST_LOCK;
                            end
                        end
                    end
                end
            end
            default: begin
                if (accept) begin
                    owner_d = win;
                    bcnt_d  = BCNT_W'(1);
                    if (MAX_BURST == 1) begin
                        ptr_d = inc_id(win);
                    end else begin
                        state_d = ST_LOCK;
                    end
                end
            end
        endcase
`else
        if (accept) begin
            ptr_d = inc_id(win);
        end
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q    <= '0;
            gnt_id_q <= '0;
            wr_cnt_q <= '0;
`ifdef FIFO_WR_ARB_BURST_EN
            state_q  <= ST_ARB;
            owner_q  <= '0;
            bcnt_q   <= '0;
`endif
        end else begin
            ptr_q    <= ptr_d;
            gnt_id_q <= gnt_id_d;
            wr_cnt_q <= wr_cnt_d;
`ifdef FIFO_WR_ARB_BURST_EN
            state_q  <= state_d;
            owner_q  <= owner_d;
            bcnt_q   <= bcnt_d;
`endif
        end
    end

    assign gnt_id_o = gnt_id_q;
    assign wr_cnt_o = wr_cnt_q;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Scoreboard bench for fifo_wr_arb; follows FIFO_WR_ARB_BURST_EN to pick the build under test.
module tb_fifo_wr_arb;

    localparam int unsigned DW = 8;
    localparam int unsigned NR = 4;
    localparam int unsigned MB = 4;

    typedef struct packed {
        logic [NR-1:0] ack;
        logic          w_inc;
        logic [DW-1:0] data;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req;
    logic [NR*DW-1:0] req_data;
    logic            full;
    logic [NR-1:0]   ack;
    logic            w_inc;
    logic [DW-1:0]   wr_data;
    logic [1:0]      gnt_id;
    logic [15:0]     wr_cnt;

    exp_t        exp_q[$];
    int          n_chk  = 0;
    int          n_pass = 0;
    logic [1:0]  exp_gnt;
    logic [15:0] exp_cnt;
    int          m_ptr, m_owner, m_bcnt;
    bit          m_lock;

    fifo_wr_arb #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .MAX_BURST  (MB)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_i      (req),
        .req_data_i (req_data),
        .full_i     (full),
        .ack_o      (ack),
        .w_inc_o    (w_inc),
        .wr_data_o  (wr_data),
        .gnt_id_o   (gnt_id),
        .wr_cnt_o   (wr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, expv, $time);
    endtask

    function automatic int first_req(input logic [NR-1:0] r, input int p);
        for (int k = 0; k < int'(NR); k++) begin
            if (r[(p + k) % NR]) return (p + k) % NR;
        end
        return -1;
    endfunction

    // Reference arbiter: returns the expected one-hot ACK and advances its own state.
    task automatic model(input logic [NR-1:0] r, input logic f, output logic [NR-1:0] e);
        int w;
        e = '0;
        w = -1;
`ifdef FIFO_WR_ARB_BURST_EN
        if (m_lock && !f) begin
            if (r[m_owner]) begin
                e = NR'(1 << m_owner);
                m_bcnt++;
                if (m_bcnt == int'(MB)) begin
                    m_lock = 1'b0;
                    m_ptr  = (m_owner + 1) % NR;
                    m_bcnt = 0;
                end
            end else begin
                m_lock = 1'b0;
                m_ptr  = (m_owner + 1) % NR;
                m_bcnt = 0;
                w = first_req(r, m_ptr);
            end
        end else if (!m_lock && !f) begin
            w = first_req(r, m_ptr);
        end
        if (w >= 0) begin
            e       = NR'(1 << w);
            m_owner = w;
            m_bcnt  = 1;
            if (MB == 1) m_ptr = (w + 1) % NR;
            else         m_lock = 1'b1;
        end
`else
        if (!f) w = first_req(r, m_ptr);
        if (w >= 0) begin
            e     = NR'(1 << w);
            m_ptr = (w + 1) % NR;
        end
`endif
    endtask

    // One cycle: drive, queue the expectation, compare comb outputs at negedge and registers after the edge.
    task automatic step(input logic [NR-1:0] r, input logic f, input logic [NR-1:0] e_ack);
        exp_t e;
        exp_t g;
        int   id;
        req  = r;
        full = f;
        id   = -1;
        for (int i = 0; i < int'(NR); i++) if (e_ack[i]) id = i;
        e.ack   = e_ack;
        e.w_inc = |e_ack;
        e.data  = (id >= 0) ? req_data[id*DW +: DW] : '0;
        exp_q.push_back(e);
        @(negedge clk);
        g = exp_q.pop_front();
        check("ack", 32'(ack), 32'(g.ack));
        check("w_inc", 32'(w_inc), 32'(g.w_inc));
        check("wr_data", 32'(wr_data), 32'(g.data));
        if (id >= 0) begin
            exp_gnt = 2'(id);
            exp_cnt = exp_cnt + 16'd1;
        end
        @(posedge clk);
        #1;
        check("gnt_id", 32'(gnt_id), 32'(exp_gnt));
        check("wr_cnt", 32'(wr_cnt), 32'(exp_cnt));
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = 4'b1111;
        full = 1'b0;
        @(negedge clk);
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_w_inc", 32'(w_inc), 32'h0);
        check("rst_wr_data", 32'(wr_data), 32'h0);
        check("rst_gnt_id", 32'(gnt_id), 32'h0);
        check("rst_wr_cnt", 32'(wr_cnt), 32'h0);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        exp_gnt = '0;
        exp_cnt = '0;
        m_ptr   = 0;
        m_owner = 0;
        m_bcnt  = 0;
        m_lock  = 1'b0;
    endtask

    initial begin
        logic [NR-1:0] r, e;
        logic          f;
        rst  = 1'b1;
        req  = '0;
        full = 1'b0;
        for (int i = 0; i < int'(NR); i++) req_data[i*DW +: DW] = 8'hA0 + 8'(i);
        repeat (2) @(posedge clk);

        do_reset();
`ifdef FIFO_WR_ARB_BURST_EN
        for (int i = 0; i < 4; i++) step(4'b1111, 1'b0, 4'b0001);
        for (int i = 0; i < 4; i++) step(4'b1111, 1'b0, 4'b0010);

        do_reset();
        step(4'b1111, 1'b0, 4'b0001);
        step(4'b1111, 1'b0, 4'b0001);
        step(4'b1110, 1'b0, 4'b0010);
        step(4'b1110, 1'b0, 4'b0010);

        do_reset();
        step(4'b1111, 1'b0, 4'b0001);
        step(4'b1111, 1'b0, 4'b0001);
        step(4'b1111, 1'b1, 4'b0000);
        step(4'b1111, 1'b1, 4'b0000);
        step(4'b1111, 1'b0, 4'b0001);
        step(4'b1111, 1'b0, 4'b0001);
        step(4'b1111, 1'b0, 4'b0010);

        do_reset();
        for (int i = 0; i < 3; i++) step(4'b0110, 1'b1, 4'b0000);
        step(4'b0110, 1'b0, 4'b0010);
        step(4'b0110, 1'b0, 4'b0010);
`else
        step(4'b1111, 1'b0, 4'b0001);
        step(4'b1111, 1'b0, 4'b0010);
        step(4'b1111, 1'b0, 4'b0100);
        step(4'b1111, 1'b0, 4'b1000);
        step(4'b1111, 1'b0, 4'b0001);
        check("wr_cnt_after_5", 32'(wr_cnt), 32'd5);

        do_reset();
        for (int i = 0; i < 3; i++) step(4'b0110, 1'b1, 4'b0000);
        step(4'b0110, 1'b0, 4'b0010);
        step(4'b0110, 1'b0, 4'b0100);

        do_reset();
        step(4'b1001, 1'b0, 4'b0001);
        step(4'b1001, 1'b0, 4'b1000);
        step(4'b1001, 1'b0, 4'b0001);
`endif

        // Counter wrap: a lone requester is accepted every cycle.
        do_reset();
        req = 4'b0001;
        repeat (65537) @(posedge clk);
        #1;
        check("wr_cnt_wrap", 32'(wr_cnt), 32'h0001);
        check("gnt_id_wrap", 32'(gnt_id), 32'h0);

        do_reset();
        for (int n = 0; n < 400; n++) begin
            r = NR'($urandom);
            f = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < int'(NR); i++) req_data[i*DW +: DW] = DW'($urandom);
            model(r, f, e);
            step(r, f, e);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arb.md
# fifo_wr_arb

Round-robin write-port arbiter for the asynchronous FIFO. It shares the FIFO write side (W_INC/WR_DATA, gated by FULL) among NUM_REQ requesters in the write clock domain. Per cycle it grants at most one requester, forwards that requester's word into the FIFO and returns a same-cycle acknowledge. It sits between the producer blocks and the FIFO write port, clocked by the FIFO write clock.

## Interface
- DATA_WIDTH, 8, word width; must match the FIFO DATA_WIDTH
- NUM_REQ, 4, number of requesters, 2..8
- MAX_BURST, 4, maximum consecutive words per grant in burst mode, 1..15
- CLK  in  1  write-domain clock (the FIFO W_CLK)
- RST  in  1  asynchronous, active-high reset
- REQ  in  NUM_REQ  per-requester valid; word i is offered while REQ[i]=1
- REQ_DATA  in  NUM_REQ*DATA_WIDTH  flattened data; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
- FULL  in  1  FIFO full flag, write domain
- ACK  out  NUM_REQ  one-hot; ACK[i]=1 means word i is written at this CLK edge
- W_INC  out  1  FIFO write enable
- WR_DATA  out  DATA_WIDTH  FIFO write data
- GNT_ID  out  $clog2(NUM_REQ)  index of the last accepted requester (registered)
- WR_CNT  out  16  count of accepted words, wraps modulo 2^16

## Operation
- The clock is single and the reset is asynchronous and active-high.
- Registered state:
  - PTR: priority pointer, reset 0
  - LOCK flag, reset 0
  - OWNER, reset 0
  - BCNT, reset 0
  - GNT_ID, reset 0
  - WR_CNT, reset 0
- Combinational accept: the winner is the first index with REQ set, scanning PTR, PTR+1, … modulo NUM_REQ.
- When FULL=0 and a winner exists:
  - W_INC=1, ACK=onehot(winner), WR_DATA=REQ_DATA[winner].
  - Otherwise W_INC=0, ACK=0 and WR_DATA=0.
- While RST=1, W_INC, ACK and WR_DATA are forced to 0.
- On an accepted word:
  - GNT_ID<=winner, WR_CNT<=WR_CNT+1 (wrapping from 0xFFFF to 0).
  - PTR<=(winner+1) mod NUM_REQ (non-burst build).
- FULL=1: there is no accept and all state holds. A requester keeps REQ and its data stable until it sees ACK.
- Requesters with REQ=0 are skipped with no cycle penalty. A single active requester is granted every cycle.

## Timing
- Accept latency is 0 cycles: ACK and W_INC are asserted in the same cycle the REQ is seen, provided FULL=0.
- The FIFO captures WR_DATA on the same CLK edge.
- Throughput is 1 word per cycle while FULL=0.
- PTR, LOCK, BCNT, GNT_ID and WR_CNT update on the CLK edge that ends an accept cycle.
- Reset released mid-burst: the next cycle arbitrates from PTR=0 with LOCK=0.

## Configuration
- Macro: FIFO_WR_ARB_BURST_EN.
- Defined: two-state machine, ARB and LOCK.
  - ARB: an accept from winner w sets OWNER=w and BCNT=1.
    - If MAX_BURST=1, PTR<=w+1 and the state stays ARB.
    - Otherwise the state goes to LOCK.
  - LOCK with REQ[OWNER]=1 and FULL=0: OWNER is granted regardless of PTR, and BCNT increments.
    - When BCNT reaches MAX_BURST: return to ARB, PTR<=OWNER+1, BCNT<=0.
  - LOCK with REQ[OWNER]=0:
    - Return to ARB and set PTR<=OWNER+1.
    - In the same cycle, arbitrate normally starting from OWNER+1.
  - LOCK with FULL=1: hold OWNER, BCNT and the state.
- Undefined: no LOCK state and no BCNT logic. Every accepted word rotates PTR.

## Test plan
- Assert RST with REQ=4'b1111 and FULL=0 → ACK=0, W_INC=0, WR_DATA=0, GNT_ID=0, WR_CNT=0. On the first cycle after release → ACK=4'b0001.
- Non-burst build, REQ=4'b1111 held, data i=8'hA0+i, FULL=0 → ACK sequence 0001, 0010, 0100, 1000, 0001 and WR_DATA A0, A1, A2, A3, A0. WR_CNT reads 5 after the fifth accept.
- After reset, REQ=4'b0110 with FULL=1 for 3 cycles → W_INC=0, ACK=0, PTR=0 held. When FULL drops → ACK=0010, then 0100.
- Burst build, MAX_BURST=4, REQ=4'b1111 → ACK=0001 for 4 cycles, then 0010 for 4 cycles. With REQ[0] dropped after 2 words → ACK=0010 in that same cycle.
- Burst build, FULL=1 after the second word of a LOCK burst, held for 2 cycles → no ACK. After release, 2 more 0001 accepts, then 0010.
- Drive 65,537 accepts → WR_CNT wraps to 0x0001.
